// File: rtl/rev_xbar_alloc.sv
// rev_xbar_alloc: per-output-VC round-robin switch allocator with packet locking and credit tracking
module rev_xbar_alloc #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VCS      = 2,
  parameter int VC_ID_BITS   = $clog2(NUM_VCS),
  parameter int CREDIT_DEPTH = 4,
  parameter int CRED_BITS    = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][2:0]        req_port,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][VC_ID_BITS-1:0] req_vc,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             req_tail,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             credit_in,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0][1:0]        p_sel,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0][VC_ID_BITS-1:0] vc_sel,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0]             out_valid,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0]             pop
);
  localparam int NC = (NUM_PORTS - 1) * NUM_VCS;
  localparam int CI = $clog2(NC);

  logic [NUM_PORTS-1:0][NUM_VCS-1:0]         xfer;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][CI-1:0] win;

  // relative port index skips the output port itself
  function automatic int in_port(input int c, input int op);
    return (c / NUM_VCS < op) ? c / NUM_VCS : c / NUM_VCS + 1;
  endfunction

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_o
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_v
      logic [NC-1:0]        creq, tl;
      logic [CI-1:0]        w, lk_idx, rr;
      logic                 hit, lock;
      logic [CRED_BITS-1:0] cred;
      always_comb begin
        creq = '0;
        tl = '0;
        for (int c = 0; c < NC; c++) begin
          creq[c] = req_valid[in_port(c, o)][c % NUM_VCS] &&
                    req_port[in_port(c, o)][c % NUM_VCS] == 3'(o) &&
                    req_vc[in_port(c, o)][c % NUM_VCS] == VC_ID_BITS'(v);
          tl[c] = req_tail[in_port(c, o)][c % NUM_VCS];
        end
      end
      // descending scan so the lowest offset from rr wins
      always_comb begin
        hit = 1'b0;
        w = '0;
        if (lock) begin
          hit = creq[lk_idx];
          w = lk_idx;
        end else begin
          for (int k = NC - 1; k >= 0; k--)
            if (creq[CI'((int'(rr) + k) % NC)]) begin
              hit = 1'b1;
              w = CI'((int'(rr) + k) % NC);
            end
        end
      end
      assign xfer[o][v]      = hit && cred != '0 && !rst;
      assign win[o][v]       = w;
      assign out_valid[o][v] = xfer[o][v];
      assign p_sel[o][v]     = xfer[o][v] ? 2'(int'(w) / NUM_VCS) : '0;
      assign vc_sel[o][v]    = xfer[o][v] ? VC_ID_BITS'(int'(w) % NUM_VCS) : '0;
      always_ff @(posedge clk) begin
        if (rst) begin
          lock <= 1'b0;
          lk_idx <= '0;
          rr <= '0;
          cred <= CRED_BITS'(CREDIT_DEPTH);
        end else begin
          if (xfer[o][v]) begin
            lock <= !tl[w];
            lk_idx <= w;
            if (tl[w]) rr <= CI'((int'(w) + 1) % NC);
          end
          if (xfer[o][v] && !credit_in[o][v]) cred <= cred - 1'b1;
          else if (!xfer[o][v] && credit_in[o][v] && cred != CRED_BITS'(CREDIT_DEPTH)) cred <= cred + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = 0; j < NUM_VCS; j++)
        for (int p = 0; p < NUM_PORTS; p++)
          for (int q = 0; q < NUM_VCS; q++)
            if (i != p && xfer[p][q] && int'(win[p][q]) == (i < p ? i : i - 1) * NUM_VCS + j)
              pop[i][j] = 1'b1;
  end
endmodule
